// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-access requests onto a single memory port
// with fixed read latency, one outstanding transaction at a time.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_en,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state, stateNext;
  logic [2:0]  cnt, cntNext;
  logic        lastGntData, lastGntDataNext;
  logic        busyWr, busyWrNext;
  logic        errPend, errPendNext;
  logic        errData, errDataNext;

  logic        reqI, reqD;
  logic        grantI, grantD;
  logic        misalign;
  logic [15:0] gntAddr;
  logic        busyDone;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lastGntData <= 1'b0;
      busyWr      <= 1'b0;
      errPend     <= 1'b0;
      errData     <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      lastGntData <= lastGntDataNext;
      busyWr      <= busyWrNext;
      errPend     <= errPendNext;
      errData     <= errDataNext;
    end
  end

  // A misaligned access stays in IDLE and completes next cycle from errPend;
  // its owner's still-held request is masked so the other side can be granted then.
  always_comb begin
    reqI     = if_req & ~(errPend & ~errData);
    reqD     = dm_en  & ~(errPend &  errData);
    grantD   = (state == IDLE) & ~rst & reqD & (~reqI | ~lastGntData);
    grantI   = (state == IDLE) & ~rst & reqI & ~grantD;
    gntAddr  = grantD ? dm_addr : if_addr;
    misalign = gntAddr[0];
    busyDone = (state != IDLE) & (cnt == 3'd0);

    stateNext       = state;
    cntNext         = cnt;
    lastGntDataNext = lastGntData;
    busyWrNext      = busyWr;
    errPendNext     = 1'b0;
    errDataNext     = errData;

    case (state)
      IDLE: begin
        if (grantI || grantD) begin
          lastGntDataNext = grantD;
          busyWrNext      = grantD & dm_wr;
          errDataNext     = grantD;
          if (misalign) begin
            errPendNext = 1'b1;
          end else begin
            stateNext = grantD ? BUSY_D : BUSY_I;
            cntNext   = 3'(MEM_LAT - 1);
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt == 3'd0) begin
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 3'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = (grantI | (grantD & ~dm_wr)) & ~misalign;
    mem_wr    = grantD & dm_wr & ~misalign;
    mem_addr  = (mem_rd | mem_wr) ? gntAddr : '0;
    mem_wdata = mem_wr ? dm_wdata : '0;

    if_done  = ~rst & ((busyDone & (state == BUSY_I)) | (errPend & ~errData));
    dm_done  = ~rst & ((busyDone & (state == BUSY_D)) | (errPend &  errData));
    err      = ~rst & errPend;

    if_rdata = (~rst & busyDone & (state == BUSY_I)) ? mem_rdata : '0;
    dm_rdata = (~rst & busyDone & (state == BUSY_D) & ~busyWr) ? mem_rdata : '0;

    if_stall = ~rst & if_req & ~if_done;
    dm_stall = ~rst & dm_en  & ~dm_done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios on a MEM_LAT=2 instance,
// plus latency sweeps on MEM_LAT=1 and MEM_LAT=7 instances.
module tb_mem_arbiter;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cyc;
  } strobe_t;

  typedef struct {
    bit          isData;
    logic [15:0] rdata;
    bit          err;
    int          cyc;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic sweepGo = 1'b0;
  int   sweepFin = 0;

  strobe_t strQ[$];
  done_t   doneQ[$];
  strobe_t sPop;
  done_t   dPop;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        ifReq, dmEn, dmWr;
  logic [15:0] ifAddr, dmAddr, dmWdata;
  logic [15:0] ifRdata, dmRdata, memAddr, memWdata, memRdata;
  logic        ifDone, ifStall, dmDone, dmStall, memRd, memWr, errO;

  mem_arbiter #(.MEM_LAT(2)) uMain (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_done(ifDone), .if_stall(ifStall),
    .dm_en(dmEn), .dm_wr(dmWr), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata), .dm_done(dmDone), .dm_stall(dmStall),
    .mem_rd(memRd), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .err(errO)
  );

  // Memory model: data = addr ^ A5B5 exactly 2 cycles after mem_rd, junk otherwise
  int          rdyCyc = -1;
  logic [15:0] rdyAddr = '0;
  always @(posedge clk) if (memRd) begin rdyCyc <= cyc + 2; rdyAddr <= memAddr; end
  assign memRdata = (cyc == rdyCyc) ? (rdyAddr ^ 16'hA5B5) : 16'hDEAD;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expStrobe(input bit wr, input logic [15:0] a, input logic [15:0] d, input int c);
    strobe_t s;
    s.wr = wr; s.addr = a; s.wdata = d; s.cyc = c;
    strQ.push_back(s);
  endtask

  task automatic expDone(input bit isD, input logic [15:0] rd, input bit e, input int c);
    done_t x;
    x.isData = isD; x.rdata = rd; x.err = e; x.cyc = c;
    doneQ.push_back(x);
  endtask

  always @(negedge clk) begin
    if (memRd && memWr) begin
      errors++;
      $display("FAIL strobe_excl: mem_rd and mem_wr both high at cycle %0d", cyc);
    end
    if (memRd || memWr) begin
      checks++;
      if (strQ.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected rd=%0b wr=%0b addr=%h at cycle %0d", memRd, memWr, memAddr, cyc);
      end else begin
        sPop = strQ.pop_front();
        if (memWr !== sPop.wr || memRd !== !sPop.wr || memAddr !== sPop.addr ||
            memWdata !== sPop.wdata || cyc != sPop.cyc) begin
          errors++;
          $display("FAIL strobe: got wr=%0b addr=%h wdata=%h cyc=%0d, want wr=%0b addr=%h wdata=%h cyc=%0d",
                   memWr, memAddr, memWdata, cyc, sPop.wr, sPop.addr, sPop.wdata, sPop.cyc);
        end
      end
    end
    if (ifDone || dmDone) begin
      checks++;
      if (doneQ.size() == 0) begin
        errors++;
        $display("FAIL done: unexpected if_done=%0b dm_done=%0b at cycle %0d", ifDone, dmDone, cyc);
      end else begin
        dPop = doneQ.pop_front();
        if ((ifDone && dmDone) || dmDone !== dPop.isData || errO !== dPop.err || cyc != dPop.cyc ||
            (dPop.isData ? dmRdata : ifRdata) !== dPop.rdata) begin
          errors++;
          $display("FAIL done: got dm=%0b err=%0b rdata=%h/%h cyc=%0d, want dm=%0b err=%0b rdata=%h cyc=%0d",
                   dmDone, errO, ifRdata, dmRdata, cyc, dPop.isData, dPop.err, dPop.rdata, dPop.cyc);
        end
      end
    end
  end

  task automatic chkQuiet(input string nm);
    @(negedge clk);
    checks++;
    if ({memRd, memWr, ifDone, dmDone, errO, ifStall, dmStall} !== 7'b0 ||
        ifRdata !== 16'h0 || dmRdata !== 16'h0 || memAddr !== 16'h0 || memWdata !== 16'h0) begin
      errors++;
      $display("FAIL %s: outputs rd=%0b wr=%0b ifd=%0b dmd=%0b err=%0b stall=%0b%0b addr=%h, want all 0",
               nm, memRd, memWr, ifDone, dmDone, errO, ifStall, dmStall, memAddr);
    end
  endtask

  task automatic chkStall(input logic want);
    @(negedge clk);
    checks++;
    if (ifStall !== want) begin
      errors++;
      $display("FAIL if_stall: got %0b want %0b at cycle %0d", ifStall, want, cyc);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    ifReq = 1'b1; ifAddr = 16'h0010;
    dmEn = 1'b1; dmWr = 1'b0; dmAddr = 16'h0200; dmWdata = 16'h0;
    tick(1);
    repeat (3) begin chkQuiet("reset_hold"); tick(1); end

    // Both pending after reset: data first, then alternate D,I,D,I
    rst = 1'b0;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        expStrobe(1'b0, 16'h0200, 16'h0, t + 3*k);
        expDone(1'b1, 16'hA7B5, 1'b0, t + 3*k + 2);
      end else begin
        expStrobe(1'b0, 16'h0010, 16'h0, t + 3*k);
        expDone(1'b0, 16'hA5A5, 1'b0, t + 3*k + 2);
      end
    end
    tick(12);
    ifReq = 1'b0; dmEn = 1'b0;
    tick(1);

    // Fetch only, held: throughput one per 3 cycles
    t = cyc;
    ifReq = 1'b1; ifAddr = 16'h0010;
    expStrobe(1'b0, 16'h0010, 16'h0, t);     expDone(1'b0, 16'hA5A5, 1'b0, t + 2);
    expStrobe(1'b0, 16'h0010, 16'h0, t + 3); expDone(1'b0, 16'hA5A5, 1'b0, t + 5);
    chkStall(1'b1); tick(1);
    chkStall(1'b1); tick(1);
    chkStall(1'b0); tick(4);
    ifReq = 1'b0;
    tick(1);

    // Misaligned load wins tie (last grant was fetch); fetch granted in the err cycle
    t = cyc;
    dmEn = 1'b1; dmWr = 1'b0; dmAddr = 16'h0041;
    ifReq = 1'b1; ifAddr = 16'h0010;
    expDone(1'b1, 16'h0000, 1'b1, t + 1);
    expStrobe(1'b0, 16'h0010, 16'h0, t + 1);
    expDone(1'b0, 16'hA5A5, 1'b0, t + 3);
    tick(2); dmEn = 1'b0;
    tick(2); ifReq = 1'b0;
    tick(1);

    // Store, request dropped while busy: still completes
    t = cyc;
    dmEn = 1'b1; dmWr = 1'b1; dmAddr = 16'h0040; dmWdata = 16'h1234;
    expStrobe(1'b1, 16'h0040, 16'h1234, t);
    expDone(1'b1, 16'h0000, 1'b0, t + 2);
    tick(1); dmEn = 1'b0; dmWr = 1'b0;
    tick(2);

    // Reset mid-fetch: no completion, regrant right after reset falls
    t = cyc;
    ifReq = 1'b1; ifAddr = 16'h0080;
    expStrobe(1'b0, 16'h0080, 16'h0, t);
    tick(1); rst = 1'b1;
    tick(1); chkQuiet("reset_mid");
    tick(1); rst = 1'b0;
    expStrobe(1'b0, 16'h0080, 16'h0, t + 3);
    expDone(1'b0, 16'hA535, 1'b0, t + 5);
    tick(3); ifReq = 1'b0;
    tick(2);

    sweepGo = 1'b1;
    for (int k = 0; k < 2000 && sweepFin < 2; k++) tick(1);
    checks++;
    if (sweepFin < 2) begin
      errors++;
      $display("FAIL sweep_timeout: finished %0d of 2 sweeps", sweepFin);
    end
    checks++;
    if (strQ.size() != 0 || doneQ.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d strobes and %0d dones never seen, want 0", strQ.size(), doneQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gSweep
    localparam int L = (gi == 0) ? 1 : 7;
    logic        sIfReq, sDmEn, sDmWr;
    logic [15:0] sIfAddr, sDmAddr, sDmWdata;
    logic [15:0] sIfRdata, sDmRdata, sMemAddr, sMemWdata, sMemRdata;
    logic        sIfDone, sIfStall, sDmDone, sDmStall, sMemRd, sMemWr, sErr;
    int          sRdy = -1;
    logic [15:0] sRdyAddr = '0;
    int          sCyc = -1;
    logic [15:0] sAddr = '0;
    bit          sWr = 1'b0;

    mem_arbiter #(.MEM_LAT(L)) uSw (
      .clk(clk), .rst(rst),
      .if_req(sIfReq), .if_addr(sIfAddr), .if_rdata(sIfRdata), .if_done(sIfDone), .if_stall(sIfStall),
      .dm_en(sDmEn), .dm_wr(sDmWr), .dm_addr(sDmAddr), .dm_wdata(sDmWdata),
      .dm_rdata(sDmRdata), .dm_done(sDmDone), .dm_stall(sDmStall),
      .mem_rd(sMemRd), .mem_wr(sMemWr), .mem_addr(sMemAddr), .mem_wdata(sMemWdata),
      .mem_rdata(sMemRdata), .err(sErr)
    );

    always @(posedge clk) if (sMemRd) begin sRdy <= cyc + L; sRdyAddr <= sMemAddr; end
    assign sMemRdata = (cyc == sRdy) ? (sRdyAddr ^ 16'hA5B5) : 16'hDEAD;

    always @(negedge clk) begin
      if (sMemRd && sMemWr) begin
        errors++;
        $display("FAIL sweep%0d_excl: mem_rd and mem_wr both high at cycle %0d", L, cyc);
      end
      if (sMemRd || sMemWr) begin sCyc = cyc; sAddr = sMemAddr; sWr = sMemWr; end
      if (sIfDone || sDmDone) begin
        checks++;
        if (cyc != sCyc + L || (sIfRdata | sDmRdata) !== (sWr ? 16'h0 : (sAddr ^ 16'hA5B5))) begin
          errors++;
          $display("FAIL sweep%0d_done: cyc=%0d rdata=%h, want cyc=%0d rdata=%h",
                   L, cyc, sIfRdata | sDmRdata, sCyc + L, sWr ? 16'h0 : (sAddr ^ 16'hA5B5));
        end
      end
    end

    initial begin
      bit got;
      sIfReq = 1'b0; sDmEn = 1'b0; sDmWr = 1'b0;
      sIfAddr = '0; sDmAddr = '0; sDmWdata = '0;
      wait (sweepGo);
      tick(1);
      for (int n = 0; n < 6; n++) begin
        case (n % 3)
          0: begin sIfReq = 1'b1; sIfAddr = 16'h0100 + 16'(2*n); end
          1: begin sDmEn = 1'b1; sDmWr = 1'b0; sDmAddr = 16'h0100 + 16'(2*n); end
          default: begin sDmEn = 1'b1; sDmWr = 1'b1; sDmAddr = 16'h0100 + 16'(2*n); sDmWdata = 16'hBEE0 + 16'(n); end
        endcase
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
          @(negedge clk);
          if (sIfDone || sDmDone) got = 1'b1;
          else tick(1);
        end
        if (!got) begin
          errors++;
          $display("FAIL sweep%0d_timeout: no done for transaction %0d", L, n);
        end
        tick(1);
        sIfReq = 1'b0; sDmEn = 1'b0; sDmWr = 1'b0;
        tick(1);
      end
      sweepFin++;
    end
  end

endmodule
